digit_serial_adder: RTL and testbench

Parametrised multi-cycle adder that adds two WIDTH-bit operands DIGIT bits per clock, rippling the carry through a registered carry flop between digits. It is the sequential, handshaked successor of the team's combinational half-adder/full-adder cells and lets wide adds run in datapaths where a full-width ripple chain would not close timing. Operands are captured on a valid/ready input handshake. The result is presented on a valid/ready output handshake, and the block holds it under back-pressure.

---
 rtl/digit_serial_adder.sv | 160 ++++++++++++++++
 tb/tb_digit_serial_adder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/digit_serial_adder.sv
// digit_serial_adder: multi-cycle adder that adds two WIDTH-bit operands
// DIGIT bits per clock. A registered carry flop ripples the carry between
// digits. Operands are taken on a valid/ready input handshake, and the result
// is held on a valid/ready output handshake until the consumer accepts it.
//
// Optional feature: define SUBTRACT_EN to add the `sub` port (A - B - cin mode).
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operand set offered
//   in_ready   out  block idle and able to accept operands
//   a, b       in   WIDTH-bit operands
//   cin        in   carry-in (borrow-in when subtracting)
//   sub        in   (SUBTRACT_EN only) 1 selects A - B
//   out_valid  out  result valid
//   out_ready  in   consumer accepts result
//   sum        out  WIDTH-bit result
//   cout       out  carry-out of MSB (1 = no borrow when subtracting)
//   ovf        out  signed overflow
module digit_serial_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SUBTRACT_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned N    = WIDTH / DIGIT;
    localparam int unsigned CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_in_ready;
    logic             r_out_valid;

    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_cin_eff;
    logic [31:0]      w_shift;
    logic [DIGIT-1:0] w_da;
    logic [DIGIT-1:0] w_db;
    logic [DIGIT:0]   w_dsum;
    logic [WIDTH-1:0] w_mask;
    logic [WIDTH-1:0] w_sum_next;
    logic             w_ovf;

    assign w_accept = in_valid && r_in_ready;
    assign w_last   = (r_cnt == LAST);

    // Subtraction is A + ~B + ~cin, so the mode is folded into the captured B
    // and carry-in at accept time.
`ifdef SUBTRACT_EN
    assign w_b_eff   = sub ? ~b : b;
    assign w_cin_eff = sub ^ cin;
`else
    assign w_b_eff   = b;
    assign w_cin_eff = cin;
`endif

    // One digit slice of the adder, selected by the digit counter.
    assign w_shift    = 32'(r_cnt) * 32'(DIGIT);
    assign w_da       = DIGIT'(r_a >> w_shift);
    assign w_db       = DIGIT'(r_b >> w_shift);
    assign w_dsum     = {1'b0, w_da} + {1'b0, w_db} + (DIGIT + 1)'(r_carry);
    assign w_mask     = WIDTH'({DIGIT{1'b1}}) << w_shift;
    assign w_sum_next = (r_sum & ~w_mask) | (WIDTH'(w_dsum[DIGIT-1:0]) << w_shift);

    // Carry into the MSB is recovered as a^b^s at that bit position.
    assign w_ovf = w_da[DIGIT-1] ^ w_db[DIGIT-1] ^ w_dsum[DIGIT-1] ^ w_dsum[DIGIT];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept)  w_state_next = S_RUN;
            S_RUN:  if (w_last)    w_state_next = S_DONE;
            S_DONE: if (out_ready) w_state_next = S_IDLE;
            default:               w_state_next = S_IDLE;
        endcase
    end

    // Datapath and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a         <= '0;
            r_b         <= '0;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_next == S_IDLE);
            r_out_valid <= (w_state_next == S_DONE);
            if (r_state == S_IDLE && w_accept) begin
                r_a     <= a;
                r_b     <= w_b_eff;
                r_carry <= w_cin_eff;
                r_cnt   <= '0;
            end
            if (r_state == S_RUN) begin
                r_sum   <= w_sum_next;
                r_carry <= w_dsum[DIGIT];
                r_cnt   <= r_cnt + CW'(1);
                if (w_last) begin
                    r_cout <= w_dsum[DIGIT];
                    r_ovf  <= w_ovf;
                end
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Scoreboard bench for digit_serial_adder: a 16/4 instance checked through an
// expected-result queue, plus 8/8 and 8/1 instances for the degenerate widths.
module tb_digit_serial_adder;

    localparam int W = 16;
    localparam int D = 4;
    localparam int N = W / D;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          cin;
`ifdef SUBTRACT_EN
    logic          sub;
`endif
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  sum;
    logic          cout;
    logic          ovf;

    // Shared stimulus for the two 8-bit instances.
    logic [7:0] s_a, s_b;
    logic       s_cin, s_v8, s_v1, s_out_ready;
    logic       x8_in_ready, x8_out_valid, x8_cout, x8_ovf;
    logic       x1_in_ready, x1_out_valid, x1_cout, x1_ovf;
    logic [7:0] x8_sum, x1_sum;

    digit_serial_adder #(.WIDTH(W), .DIGIT(D)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
`ifdef SUBTRACT_EN
        .sub(sub),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    digit_serial_adder #(.WIDTH(8), .DIGIT(8)) u_d8 (
        .clk(clk), .rst_n(rst_n), .in_valid(s_v8), .in_ready(x8_in_ready),
        .a(s_a), .b(s_b), .cin(s_cin),
`ifdef SUBTRACT_EN
        .sub(1'b0),
`endif
        .out_valid(x8_out_valid), .out_ready(s_out_ready),
        .sum(x8_sum), .cout(x8_cout), .ovf(x8_ovf)
    );

    digit_serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(s_v1), .in_ready(x1_in_ready),
        .a(s_a), .b(s_b), .cin(s_cin),
`ifdef SUBTRACT_EN
        .sub(1'b0),
`endif
        .out_valid(x1_out_valid), .out_ready(s_out_ready),
        .sum(x1_sum), .cout(x1_cout), .ovf(x1_ovf)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           acc;
        string        name;
    } exp_t;

    exp_t q[$];

    // Monitor: compares each new result against the oldest expectation.
    logic prev_ov = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ov <= 1'b0;
        end else begin
            if (out_valid && !prev_ov) begin
                if (q.size() == 0) begin
                    chk("unexpected_result", 32'(1), 32'(0));
                end else begin
                    chk({q[0].name, "_sum"},  32'(sum),  32'(q[0].sum));
                    chk({q[0].name, "_cout"}, 32'(cout), 32'(q[0].cout));
                    chk({q[0].name, "_ovf"},  32'(ovf),  32'(q[0].ovf));
                    chk({q[0].name, "_latency"}, 32'(cyc - q[0].acc), 32'(N));
                    void'(q.pop_front());
                end
            end
            prev_ov <= out_valid;
        end
    end

    // Offer one operand set; optionally push the expected result on accept.
    task automatic issue(input string name, input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic icin, input logic push,
                         input logic [W-1:0] es, input logic ec, input logic eo);
        exp_t e;
        int t;
        @(negedge clk);
        a = ia; b = ib; cin = icin; in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            chk({name, "_accept_timeout"}, 32'(0), 32'(1));
            in_valid = 1'b0;
            return;
        end
        if (push) begin
            e.sum = es; e.cout = ec; e.ovf = eo; e.acc = cyc + 1; e.name = name;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // Operands are free to change once captured.
        a = ~ia; b = ~ib; cin = ~icin;
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (q.size() != 0) begin
            chk({name, "_drain_timeout"}, 32'(q.size()), 32'(0));
            q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    // Directed run on one of the 8-bit instances (sel 0: 8/8, sel 1: 8/1).
    task automatic run_small(input string name, input int sel, input logic [7:0] ia,
                             input logic [7:0] ib, input logic ic, input logic [7:0] es,
                             input logic ec, input logic eo, input int elat);
        int t0;
        int t;
        @(negedge clk);
        s_a = ia; s_b = ib; s_cin = ic;
        chk({name, "_in_ready"}, 32'(sel == 0 ? x8_in_ready : x1_in_ready), 32'(1));
        if (sel == 0) s_v8 = 1'b1; else s_v1 = 1'b1;
        t0 = cyc + 1;
        @(posedge clk);
        #1;
        s_v8 = 1'b0; s_v1 = 1'b0;
        @(negedge clk);
        t = 0;
        while (!(sel == 0 ? x8_out_valid : x1_out_valid) && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!(sel == 0 ? x8_out_valid : x1_out_valid)) begin
            chk({name, "_valid_timeout"}, 32'(0), 32'(1));
        end else begin
            chk({name, "_latency"}, 32'(cyc - t0), 32'(elat));
            chk({name, "_sum"},  32'(sel == 0 ? x8_sum  : x1_sum),  32'(es));
            chk({name, "_cout"}, 32'(sel == 0 ? x8_cout : x1_cout), 32'(ec));
            chk({name, "_ovf"},  32'(sel == 0 ? x8_ovf  : x1_ovf),  32'(eo));
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int t;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0;
`ifdef SUBTRACT_EN
        sub = 1'b0;
`endif
        s_a = '0; s_b = '0; s_cin = 1'b0; s_v8 = 1'b0; s_v1 = 1'b0; s_out_ready = 1'b1;

        #12;
        chk("por_out_valid", 32'(out_valid), 32'(0));
        chk("por_sum",       32'(sum),       32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("por_in_ready",  32'(in_ready),  32'(1));

        // Basic add and carry/overflow corners.
        issue("basic",   16'h1234, 16'h4321, 1'b0, 1'b1, 16'h5555, 1'b0, 1'b0);
        issue("ripple",  16'hFFFF, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);
        issue("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1);
        issue("ovf_neg", 16'h8000, 16'h8000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1);
        issue("mixed",   16'h00FF, 16'h0F01, 1'b1, 1'b1, 16'h1001, 1'b0, 1'b0);
        drain("add");

`ifdef SUBTRACT_EN
        sub = 1'b1;
        issue("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        issue("sub_pos", 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
        sub = 1'b0;
        drain("sub");
`endif

        // Back-pressure: result and status frozen while out_ready is low.
        out_ready = 1'b0;
        issue("bp", 16'hA5A5, 16'h1111, 1'b0, 1'b1, 16'hB6B6, 1'b0, 1'b0);
        t = 0;
        while (!out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("bp_valid_seen", 32'(out_valid), 32'(1));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_hold_valid",    32'(out_valid), 32'(1));
            chk("bp_hold_sum",      32'(sum),       32'(16'hB6B6));
            chk("bp_hold_cout",     32'(cout),      32'(0));
            chk("bp_hold_in_ready", 32'(in_ready),  32'(0));
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready",  32'(in_ready),  32'(1));
        chk("bp_release_out_valid", 32'(out_valid), 32'(0));
        drain("bp");

        // Reset in the middle of RUN discards the operation.
        issue("midrun", 16'h1111, 16'h2222, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_sum",       32'(sum),       32'(0));
        chk("rst_cout",      32'(cout),      32'(0));
        chk("rst_ovf",       32'(ovf),       32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready",  32'(in_ready),  32'(1));
        chk("rst_no_valid",  32'(out_valid), 32'(0));
        issue("after_rst", 16'h1234, 16'h4321, 1'b0, 1'b1, 16'h5555, 1'b0, 1'b0);
        drain("after_rst");

        // Degenerate digit widths.
        run_small("d8", 0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1);
        run_small("d1", 1, 8'h5A, 8'h3C, 1'b1, 8'h97, 1'b0, 1'b1, 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
